// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and constants for the shared-adder arbiter.
// Flag vector layout is {N, Z, C, V}.
package adder_arb_pkg;
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // V is the carry into the MSB xor the carry out of it
  function automatic logic [3:0] calc_flags(input logic [DATA_W-1:0] s,
                                            input logic [DATA_W-1:0] co);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = s[DATA_W-1];
    f[FLAG_Z] = (s == '0);
    f[FLAG_C] = co[DATA_W-1];
    f[FLAG_V] = co[DATA_W-1] ^ co[DATA_W-2];
    return f;
  endfunction
endpackage

// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle between requesters, consumer and the arbiter.
// master = requester/consumer side, slave = arbiter side.
interface adder_share_arbiter_if #(parameter int NREQ = 4);
  import adder_arb_pkg::*;
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0][DATA_W-1:0] req_a;
  logic [NREQ-1:0][DATA_W-1:0] req_b;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [IDW-1:0]              rsp_id;
  logic [DATA_W-1:0]           rsp_sum;
  logic [3:0]                  rsp_flags;

  modport master (output req_valid, req_a, req_b, rsp_ready,
                  input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_flags);
  modport slave  (input  req_valid, req_a, req_b, rsp_ready,
                  output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_flags);
endinterface

// File: rtl/adder_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid request after 'last',
// scanning last+1, last+2, ... modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IDW-1:0]  gnt_idx
);
  int w_idx;

  // Scan farthest-first so the nearest valid offset overwrites the rest
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    w_idx      = 0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = (int'(last) + k) % NREQ;
      if (req[w_idx]) begin
        gnt_onehot        = '0;
        gnt_onehot[w_idx] = 1'b1;
        gnt_idx           = IDW'(w_idx);
      end
    end
  end
endmodule

// File: rtl/rca64.sv
// 64-bit ripple-carry adder with carry-in tied to zero.
// Exposes every bit's carry-out so callers can derive overflow.
module rca64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] sum,
  output logic [63:0] cout
);
  for (genvar i = 0; i < 64; i++) begin : g_bit
    logic w_cin;
    if (i == 0) begin : g_lsb
      assign w_cin = 1'b0;
    end else begin : g_up
      assign w_cin = cout[i-1];
    end
    assign sum[i]  = a[i] ^ b[i] ^ w_cin;
    assign cout[i] = (a[i] & b[i]) | (w_cin & (a[i] ^ b[i]));
  end
endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one 64-bit ripple adder among NREQ requesters: grant, hold operands
// SETTLE cycles for the carry chain, capture sum/flags, hand off with backpressure.
module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  adder_share_arbiter_if.slave  bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(SETTLE + 1);

  arb_state_t        r_state, w_next;
  logic [DATA_W-1:0] r_op_a, r_op_b, r_sum;
  logic [3:0]        r_flags;
  logic [IDW-1:0]    r_last, r_id;
  logic [CW-1:0]     r_cnt;

  logic [NREQ-1:0]   w_gnt_oh;
  logic [IDW-1:0]    w_gnt_idx;
  logic [DATA_W-1:0] w_sum, w_cout;
  logic [3:0]        w_flags;
  logic              w_accept, w_capture;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req        (bus.req_valid),
    .last       (r_last),
    .gnt_onehot (w_gnt_oh),
    .gnt_idx    (w_gnt_idx)
  );

  rca64 u_add (
    .a    (r_op_a),
    .b    (r_op_b),
    .sum  (w_sum),
    .cout (w_cout)
  );

  assign w_flags = calc_flags(w_sum, w_cout);

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: if (|bus.req_valid) begin
        w_accept = 1'b1;
        w_next   = BUSY;
      end
      BUSY: if (r_cnt == CW'(1)) begin
        w_capture = 1'b1;
        w_next    = DONE;
      end
      DONE: if (bus.rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Requester 0 has first priority out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_id    <= '0;
      r_last  <= IDW'(NREQ - 1);
      r_cnt   <= '0;
      r_sum   <= '0;
      r_flags <= '0;
    end else begin
      if (w_accept) begin
        r_op_a <= bus.req_a[w_gnt_idx];
        r_op_b <= bus.req_b[w_gnt_idx];
        r_id   <= w_gnt_idx;
        r_last <= w_gnt_idx;
        r_cnt  <= CW'(SETTLE);
      end else if (r_state == BUSY) begin
        r_cnt  <= r_cnt - CW'(1);
      end
      if (w_capture) begin
        r_sum   <= w_sum;
        r_flags <= w_flags;
      end
    end
  end

  // Gated by reset so no grant is visible while reset is held
  assign bus.req_ready = (r_state == IDLE && !reset) ? w_gnt_oh : '0;
  assign bus.rsp_valid = (r_state == DONE);
  assign bus.rsp_id    = r_id;
  assign bus.rsp_sum   = r_sum;
  assign bus.rsp_flags = r_flags;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter (NREQ=4, SETTLE=2).
module tb_adder_share_arbiter;
  logic clk;
  logic reset;
  int   n_chk, n_bad, cyc;

  adder_share_arbiter_if #(.NREQ(4)) bus ();

  adder_share_arbiter #(.NREQ(4), .SETTLE(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("rsp_timeout", {63'd0, bus.rsp_valid}, 64'd1);
  endtask

  // Present a lone request, wait for its grant, accept, drop it, wait for DONE
  task automatic run_one(input int idx, input logic [63:0] a, input logic [63:0] b);
    int n;
    bus.req_valid      = '0;
    bus.req_valid[idx] = 1'b1;
    bus.req_a[idx]     = a;
    bus.req_b[idx]     = b;
    #1;
    n = 0;
    while (!bus.req_ready[idx] && n < 20) begin
      tick();
      n++;
    end
    chk("grant", {60'd0, bus.req_ready}, 64'd1 << idx);
    tick();
    bus.req_valid = '0;
    wait_rsp();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  int last_cyc;

  initial begin
    n_chk = 0; n_bad = 0; cyc = 0;
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    #12;
    chk("rst_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rst_ready", {60'd0, bus.req_ready}, 64'd0);
    chk("rst_id",    {62'd0, bus.rsp_id}, 64'd0);
    chk("rst_sum",   bus.rsp_sum, 64'd0);
    chk("rst_flags", {60'd0, bus.rsp_flags}, 64'd0);
    reset = 1'b0;

    // single add 5+7
    bus.req_valid = 4'b0001;
    bus.req_a[0]  = 64'd5;
    bus.req_b[0]  = 64'd7;
    #1;
    chk("t1_ready", {60'd0, bus.req_ready}, 64'h1);
    tick();
    bus.req_valid = '0;
    chk("t1_busy0", {63'd0, bus.rsp_valid}, 64'd0);
    tick();
    chk("t1_busy1", {63'd0, bus.rsp_valid}, 64'd0);
    tick();
    chk("t1_valid", {63'd0, bus.rsp_valid}, 64'd1);
    chk("t1_sum",   bus.rsp_sum, 64'd12);
    chk("t1_id",    {62'd0, bus.rsp_id}, 64'd0);
    chk("t1_flags", {60'd0, bus.rsp_flags}, 64'h0);
    tick();
    chk("t1_drop",  {63'd0, bus.rsp_valid}, 64'd0);

    // round robin with all four requesters valid
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i] = 64'(i);
      bus.req_b[i] = 64'd100;
    end
    bus.req_valid = 4'b1111;
    last_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      wait_rsp();
      chk("rr_id",  {62'd0, bus.rsp_id}, 64'(k % 4));
      chk("rr_sum", bus.rsp_sum, 64'd100 + 64'(k % 4));
      if (k > 0) chk("rr_gap", 64'(cyc - last_cyc), 64'd4);
      last_cyc = cyc;
      if (k == 4) bus.req_valid = '0;
      tick();
    end

    // flag corner cases
    run_one(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    chk("ovf_sum",   bus.rsp_sum, 64'h8000_0000_0000_0000);
    chk("ovf_flags", {60'd0, bus.rsp_flags}, 64'h9);
    tick();
    run_one(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    chk("cy_sum",   bus.rsp_sum, 64'd0);
    chk("cy_flags", {60'd0, bus.rsp_flags}, 64'h6);
    tick();
    run_one(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    chk("neg_sum",   bus.rsp_sum, 64'd0);
    chk("neg_flags", {60'd0, bus.rsp_flags}, 64'h7);
    tick();

    // backpressure while requester 2 waits
    bus.rsp_ready = 1'b0;
    run_one(0, 64'd10, 64'd20);
    bus.req_valid = 4'b0100;
    bus.req_a[2]  = 64'd1;
    bus.req_b[2]  = 64'd2;
    repeat (5) begin
      tick();
      chk("bp_valid", {63'd0, bus.rsp_valid}, 64'd1);
      chk("bp_sum",   bus.rsp_sum, 64'd30);
      chk("bp_id",    {62'd0, bus.rsp_id}, 64'd0);
      chk("bp_ready", {60'd0, bus.req_ready}, 64'h0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_rdy_done", {60'd0, bus.req_ready}, 64'h0);
    tick();
    chk("bp_idle_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("bp_grant2",     {60'd0, bus.req_ready}, 64'h4);
    tick();
    bus.req_valid = '0;
    wait_rsp();
    chk("bp_sum2", bus.rsp_sum, 64'd3);
    chk("bp_id2",  {62'd0, bus.rsp_id}, 64'd2);
    tick();

    // reset in BUSY
    bus.req_valid = 4'b1000;
    bus.req_a[3]  = 64'd1;
    bus.req_b[3]  = 64'd1;
    #1;
    chk("rb_grant3", {60'd0, bus.req_ready}, 64'h8);
    tick();
    bus.req_valid = '0;
    tick();
    reset = 1'b1;
    #1;
    chk("rb_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rb_ready", {60'd0, bus.req_ready}, 64'h0);
    chk("rb_sum",   bus.rsp_sum, 64'd0);
    bus.req_valid = 4'b0011;
    bus.req_a[0] = 64'd40; bus.req_b[0] = 64'd2;
    bus.req_a[1] = 64'd50; bus.req_b[1] = 64'd5;
    #1;
    chk("rb_held", {60'd0, bus.req_ready}, 64'h0);
    reset = 1'b0;
    #1;
    chk("rb_prio0", {60'd0, bus.req_ready}, 64'h1);
    tick();
    bus.req_valid = '0;
    wait_rsp();
    chk("rb_id",  {62'd0, bus.rsp_id}, 64'd0);
    chk("rb_sum2", bus.rsp_sum, 64'd42);
    tick();

    // late arrival of requester 1 during requester 3's operation
    bus.req_valid = 4'b1000;
    bus.req_a[3] = 64'h10;  bus.req_b[3] = 64'h20;
    #1;
    chk("la_grant3", {60'd0, bus.req_ready}, 64'h8);
    tick();
    bus.req_valid = 4'b0010;
    bus.req_a[1] = 64'h100; bus.req_b[1] = 64'h200;
    #1;
    chk("la_busy_rdy", {60'd0, bus.req_ready}, 64'h0);
    wait_rsp();
    chk("la_id3",  {62'd0, bus.rsp_id}, 64'd3);
    chk("la_sum3", bus.rsp_sum, 64'h30);
    tick();
    chk("la_grant1", {60'd0, bus.req_ready}, 64'h2);
    tick();
    bus.req_valid = '0;
    wait_rsp();
    chk("la_id1",  {62'd0, bus.rsp_id}, 64'd1);
    chk("la_sum1", bus.rsp_sum, 64'h300);
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
